// File: rtl/demultiplexer_st.sv
// Avalon-ST 1:2 packet demultiplexer: routes whole packets by one channel bit into two 2-entry output buffers.
// Optional build macro DEMUX_DROP_ORPHAN_EN: discard orphan (non-sop) beats seen in IDLE instead of sending them to output one.

module demux_fifo2 #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  output logic             full,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data
);

  logic [width-1:0] mem [2];
  logic [1:0]       count;
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign valid   = (count != 2'd0);
  assign data    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = valid && ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= !wr_ptr;
      if (do_pop)  rd_ptr <= !rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

module demultiplexer_st #(
  parameter int unsigned data_width    = 128,
  parameter int unsigned empty_width   = 2,
  parameter int unsigned channel_width = 1,
  parameter int unsigned sel_bit       = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [channel_width-1:0] avsi_channel,
  input  logic [data_width-1:0]    avsi_data,
  input  logic [empty_width-1:0]   avsi_empty,
  input  logic                     avsi_valid,
  input  logic                     avsi_sop,
  input  logic                     avsi_eop,
  output logic                     avsi_ready,
  output logic [channel_width-1:0] avso_one_channel,
  output logic [data_width-1:0]    avso_one_data,
  output logic [empty_width-1:0]   avso_one_empty,
  output logic                     avso_one_valid,
  output logic                     avso_one_sop,
  output logic                     avso_one_eop,
  input  logic                     avso_one_ready,
  output logic [channel_width-1:0] avso_two_channel,
  output logic [data_width-1:0]    avso_two_data,
  output logic [empty_width-1:0]   avso_two_empty,
  output logic                     avso_two_valid,
  output logic                     avso_two_sop,
  output logic                     avso_two_eop,
  input  logic                     avso_two_ready,
  output logic                     protocol_err
);

  localparam int unsigned beat_width = channel_width + data_width + empty_width + 2;

  typedef enum logic [1:0] {IDLE, PKT_ONE, PKT_TWO} state_t;

  state_t                   state;
  logic                     in_v;
  logic [channel_width-1:0] in_ch;
  logic [data_width-1:0]    in_data;
  logic [empty_width-1:0]   in_empty;
  logic                     in_sop;
  logic                     in_eop;
  logic [beat_width-1:0]    in_beat;

  logic dest;
  logic orphan;
  logic drop;
  logic fwd;
  logic consume;
  logic full_one;
  logic full_two;
  logic [beat_width-1:0] one_beat;
  logic [beat_width-1:0] two_beat;

  assign in_beat = {in_ch, in_data, in_empty, in_sop, in_eop};

  // Destination: sop beats follow their own channel bit, others follow the open packet.
  always_comb begin
    orphan = in_v && !in_sop && (state == IDLE);
    if (in_sop)                 dest = in_ch[sel_bit];
    else if (state == PKT_TWO)  dest = 1'b1;
    else                        dest = 1'b0;
`ifdef DEMUX_DROP_ORPHAN_EN
    drop = orphan;
`else
    drop = 1'b0;
`endif
    fwd     = in_v && !drop && (dest ? !full_two : !full_one);
    consume = fwd || drop;
  end

  assign avsi_ready = !in_v || consume;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_v <= 1'b0;
    else if (avsi_ready) in_v <= avsi_valid;
  end

  always_ff @(posedge clk) begin
    if (avsi_valid && avsi_ready) begin
      in_ch    <= avsi_channel;
      in_data  <= avsi_data;
      in_empty <= avsi_empty;
      in_sop   <= avsi_sop;
      in_eop   <= avsi_eop;
    end
  end

  // Packet framing FSM; advances only when the staged beat is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      protocol_err <= 1'b0;
    end else begin
      protocol_err <= 1'b0;
      if (consume) begin
        if (in_sop) begin
          protocol_err <= (state != IDLE);
          if (in_eop)    state <= IDLE;
          else if (dest) state <= PKT_TWO;
          else           state <= PKT_ONE;
        end else if (state == IDLE) begin
          protocol_err <= 1'b1;
        end else if (in_eop) begin
          state <= IDLE;
        end
      end
    end
  end

  demux_fifo2 #(.width(beat_width)) u_fifo_one (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fwd && !dest),
    .push_data (in_beat),
    .full      (full_one),
    .ready     (avso_one_ready),
    .valid     (avso_one_valid),
    .data      (one_beat)
  );

  demux_fifo2 #(.width(beat_width)) u_fifo_two (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fwd && dest),
    .push_data (in_beat),
    .full      (full_two),
    .ready     (avso_two_ready),
    .valid     (avso_two_valid),
    .data      (two_beat)
  );

  assign {avso_one_channel, avso_one_data, avso_one_empty, avso_one_sop, avso_one_eop} = one_beat;
  assign {avso_two_channel, avso_two_data, avso_two_empty, avso_two_sop, avso_two_eop} = two_beat;

endmodule

// File: tb/tb_demultiplexer_st.sv
// Directed bench for demultiplexer_st: routing, backpressure, framing errors, orphans and async reset.
module tb_demultiplexer_st;

  logic         clk;
  logic         reset_n;
  logic [0:0]   avsi_channel;
  logic [127:0] avsi_data;
  logic [1:0]   avsi_empty;
  logic         avsi_valid, avsi_sop, avsi_eop, avsi_ready;
  logic [0:0]   one_channel, two_channel;
  logic [127:0] one_data, two_data;
  logic [1:0]   one_empty, two_empty;
  logic         one_valid, one_sop, one_eop, one_ready;
  logic         two_valid, two_sop, two_eop, two_ready;
  logic         protocol_err;

  int n_checks = 0;
  int n_fail   = 0;

  demultiplexer_st dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avsi_channel     (avsi_channel),
    .avsi_data        (avsi_data),
    .avsi_empty       (avsi_empty),
    .avsi_valid       (avsi_valid),
    .avsi_sop         (avsi_sop),
    .avsi_eop         (avsi_eop),
    .avsi_ready       (avsi_ready),
    .avso_one_channel (one_channel),
    .avso_one_data    (one_data),
    .avso_one_empty   (one_empty),
    .avso_one_valid   (one_valid),
    .avso_one_sop     (one_sop),
    .avso_one_eop     (one_eop),
    .avso_one_ready   (one_ready),
    .avso_two_channel (two_channel),
    .avso_two_data    (two_data),
    .avso_two_empty   (two_empty),
    .avso_two_valid   (two_valid),
    .avso_two_sop     (two_sop),
    .avso_two_eop     (two_eop),
    .avso_two_ready   (two_ready),
    .protocol_err     (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic ch, input logic [127:0] d, input logic sop, input logic eop);
    avsi_valid   = 1'b1;
    avsi_channel = ch;
    avsi_data    = d;
    avsi_empty   = 2'd1;
    avsi_sop     = sop;
    avsi_eop     = eop;
  endtask

  task automatic idle;
    avsi_valid = 1'b0;
    avsi_sop   = 1'b0;
    avsi_eop   = 1'b0;
  endtask

  initial begin
    int  sent;
    int  rcvd;
    logic acc;

    reset_n   = 1'b0;
    one_ready = 1'b1;
    two_ready = 1'b1;
    avsi_channel = 1'b0;
    avsi_data    = '0;
    avsi_empty   = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", avsi_ready, 1);
    check("rst_one_valid", one_valid, 0);
    check("rst_two_valid", two_valid, 0);
    check("rst_err", protocol_err, 0);
    #3 reset_n = 1'b1;
    tick();

    // 4-beat packet to output one
    put(0, 128'd1, 1, 0); tick();
    check("t1_latency", one_valid, 0);
    put(0, 128'd2, 0, 0); tick();
    check("t1_v1", one_valid, 1);
    check("t1_d1", one_data, 1);
    check("t1_sop1", one_sop, 1);
    check("t1_empty1", one_empty, 1);
    check("t1_two_idle", two_valid, 0);
    put(0, 128'd3, 0, 0); tick();
    check("t1_d2", one_data, 2);
    check("t1_sop2", one_sop, 0);
    put(0, 128'd4, 0, 1); tick();
    check("t1_d3", one_data, 3);
    idle(); tick();
    check("t1_d4", one_data, 4);
    check("t1_eop4", one_eop, 1);
    check("t1_two_idle2", two_valid, 0);
    tick();
    check("t1_drain", one_valid, 0);

    // Alternating single-beat packets
    put(1, 128'hA1, 1, 1);
    check("t2_rdy1", avsi_ready, 1);
    tick();
    put(0, 128'hB2, 1, 1);
    check("t2_rdy2", avsi_ready, 1);
    tick();
    check("t2_two_v", two_valid, 1);
    check("t2_two_d", two_data, 128'hA1);
    check("t2_one_idle", one_valid, 0);
    put(1, 128'hA3, 1, 1);
    check("t2_rdy3", avsi_ready, 1);
    tick();
    check("t2_one_v", one_valid, 1);
    check("t2_one_d", one_data, 128'hB2);
    check("t2_two_gap", two_valid, 0);
    idle(); tick();
    check("t2_two_d3", two_data, 128'hA3);
    check("t2_two_ch", two_channel, 1);
    check("t2_one_idle2", one_valid, 0);
    tick();

    // Backpressure on output one during a 6-beat packet
    one_ready = 1'b0;
    put(0, 128'h11, 1, 0); tick();
    put(0, 128'h12, 0, 0); tick();
    put(0, 128'h13, 0, 0); tick();
    put(0, 128'h14, 0, 0);
    check("t3_stall", avsi_ready, 0);
    tick();
    check("t3_stall2", avsi_ready, 0);
    check("t3_hold", one_data, 128'h11);
    one_ready = 1'b1;
    sent = 3;
    rcvd = 0;
    for (int c = 0; c < 40 && rcvd < 6; c++) begin
      if (one_valid) begin
        check("t3_data", one_data, 128'h11 + 128'(rcvd));
        if (rcvd == 5) check("t3_eop", one_eop, 1);
        rcvd++;
      end
      acc = avsi_valid && avsi_ready;
      tick();
      if (acc) begin
        sent++;
        if (sent < 6) put(0, 128'h11 + 128'(sent), 0, sent == 5);
        else idle();
      end
    end
    check("t3_count", 128'(rcvd), 6);
    check("t3_two_idle", two_valid, 0);
    tick();

    // Mid-packet sop switches to output two
    one_ready = 1'b0;
    put(0, 128'h21, 1, 0); tick();
    put(0, 128'h22, 0, 0); tick();
    put(1, 128'h31, 1, 0); tick();
    check("t4_no_err_yet", protocol_err, 0);
    put(1, 128'h32, 0, 1);
    check("t4_rdy", avsi_ready, 1);
    tick();
    check("t4_err", protocol_err, 1);
    check("t4_two_d1", two_data, 128'h31);
    check("t4_two_sop", two_sop, 1);
    idle(); tick();
    check("t4_err_once", protocol_err, 0);
    check("t4_two_d2", two_data, 128'h32);
    check("t4_two_eop", two_eop, 1);
    check("t4_one_d1", one_data, 128'h21);
    check("t4_one_eop1", one_eop, 0);
    one_ready = 1'b1;
    tick();
    check("t4_one_d2", one_data, 128'h22);
    check("t4_one_eop2", one_eop, 0);
    tick();
    check("t4_one_drain", one_valid, 0);

    // Orphan beat in IDLE
    put(1, 128'h55, 0, 0); tick();
    idle(); tick();
    check("t5_err", protocol_err, 1);
    check("t5_two_idle", two_valid, 0);
`ifdef DEMUX_DROP_ORPHAN_EN
    check("t5_dropped", one_valid, 0);
`else
    check("t5_fwd_v", one_valid, 1);
    check("t5_fwd_d", one_data, 128'h55);
`endif
    tick();
    check("t5_err_clr", protocol_err, 0);

    // Asynchronous reset with both buffers occupied
    one_ready = 1'b0;
    two_ready = 1'b0;
    put(0, 128'h61, 1, 1); tick();
    put(1, 128'h62, 1, 1); tick();
    idle(); tick();
    check("t6_one_full", one_valid, 1);
    check("t6_two_full", two_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_one_clr", one_valid, 0);
    check("t6_two_clr", two_valid, 0);
    check("t6_ready", avsi_ready, 1);
    #2 reset_n = 1'b1;
    one_ready = 1'b1;
    two_ready = 1'b1;
    put(1, 128'h71, 1, 1); tick();
    idle(); tick();
    check("t6_two_v", two_valid, 1);
    check("t6_two_d", two_data, 128'h71);
    check("t6_one_idle", one_valid, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
